// File: rtl/mac_neuron_unit_if.sv
// ============================================================================
// Module : mac_neuron_unit_if
// Brief  : Start/operand stream and result bundle of the MAC neuron engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mac_neuron_unit_if #(
    parameter int DW = 8,
    parameter int N  = 4
);
    localparam int ACC_W = 2 * DW + $clog2(N);

    logic             start;
    logic             in_valid;
    logic [DW-1:0]    main_in;
    logic [DW-1:0]    weight_in;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] res_out;

    modport master (
        output start, in_valid, main_in, weight_in,
        input  in_ready, busy, done, res_out
    );

    modport slave (
        input  start, in_valid, main_in, weight_in,
        output in_ready, busy, done, res_out
    );
endinterface

`default_nettype wire

// File: rtl/mac_neuron_unit.sv
// ============================================================================
// Module : mac_neuron_unit
// Brief  : Streaming N-term multiply-accumulate neuron; optional ReLU on the
//          result when MAC_NEURON_RELU_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_neuron_unit #(
    parameter int DW     = 8,
    parameter int N      = 4,
    parameter int SIGNED = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mac_neuron_unit_if.slave   bus
);
    localparam int ACC_W = 2 * DW + $clog2(N);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] prod_q;
    logic             pvld_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic [ACC_W-1:0] res_q;

    logic             hs_d;
    logic [ACC_W-1:0] prod_d;
    logic [ACC_W-1:0] sum_d;
    logic [ACC_W-1:0] res_d;

    assign hs_d = bus.in_valid && in_ready_q;

    // Operands are widened to 2*DW before multiplying so the full product is kept.
    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [2*DW-1:0] w_prod_s;
            assign w_prod_s = $signed({{DW{bus.main_in[DW-1]}}, bus.main_in})
                            * $signed({{DW{bus.weight_in[DW-1]}}, bus.weight_in});
            assign prod_d   = ACC_W'(w_prod_s);
        end else begin : g_unsigned
            logic [2*DW-1:0] w_prod_u;
            assign w_prod_u = {{DW{1'b0}}, bus.main_in} * {{DW{1'b0}}, bus.weight_in};
            assign prod_d   = ACC_W'(w_prod_u);
        end
    endgenerate

    assign sum_d = acc_q + (pvld_q ? prod_q : '0);

`ifdef MAC_NEURON_RELU_EN
    assign res_d = ((SIGNED != 0) && sum_d[ACC_W-1]) ? '0 : sum_d;
`else
    assign res_d = sum_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            pvld_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res_q      <= '0;
        end else begin
            pvld_q <= hs_d;
            done_q <= 1'b0;
            if (hs_d) begin
                prod_q <= prod_d;
            end
            if (pvld_q) begin
                acc_q <= sum_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        pvld_q     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (hs_d) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == C_LAST) begin
                            state_q    <= S_FLUSH;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    // Last product is still in prod_q; fold it straight into the result.
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    res_q   <= res_d;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.res_out  = res_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_neuron_unit.sv
// ============================================================================
// Module : tb_mac_neuron_unit
// Brief  : Drives an unsigned and a signed MAC neuron with shared stimulus and
//          compares both against a plain-arithmetic sum-of-products model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mac_neuron_unit;
    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int ACC_W = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] main_in;
    logic [DW-1:0] weight_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0]    a_arr [N];
    logic [DW-1:0]    b_arr [N];
    int               gap_arr [N];
    logic [ACC_W-1:0] prev_u;
    logic [ACC_W-1:0] prev_s;

    mac_neuron_unit_if #(.DW(DW), .N(N)) bus_u ();
    mac_neuron_unit_if #(.DW(DW), .N(N)) bus_s ();

    assign bus_u.start     = start;
    assign bus_u.in_valid  = in_valid;
    assign bus_u.main_in   = main_in;
    assign bus_u.weight_in = weight_in;
    assign bus_s.start     = start;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.main_in   = main_in;
    assign bus_s.weight_in = weight_in;

    mac_neuron_unit #(.DW(DW), .N(N), .SIGNED(0)) u_dut_u (.clk(clk), .rst(rst), .bus(bus_u));
    mac_neuron_unit #(.DW(DW), .N(N), .SIGNED(1)) u_dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ACC_W-1:0] ref_sum(input bit sgn);
        longint s;
        s = 0;
        for (int i = 0; i < N; i++) begin
            if (sgn) s += longint'($signed(a_arr[i])) * longint'($signed(b_arr[i]));
            else     s += longint'(a_arr[i]) * longint'(b_arr[i]);
        end
`ifdef MAC_NEURON_RELU_EN
        if (sgn && s < 0) s = 0;
`endif
        return ACC_W'(s);
    endfunction

    task automatic clear_gaps();
        for (int i = 0; i < N; i++) gap_arr[i] = 0;
    endtask

    task automatic check_ctl(input string tag, input bit rdy, input bit bsy, input bit dn);
        check_eq({tag, "_ready_u"}, 64'(bus_u.in_ready), 64'(rdy));
        check_eq({tag, "_ready_s"}, 64'(bus_s.in_ready), 64'(rdy));
        check_eq({tag, "_busy"},    64'(bus_s.busy),     64'(bsy));
        check_eq({tag, "_done"},    64'(bus_u.done),     64'(dn));
    endtask

    // noisy: stray start pulses and a surplus pair; chain: start held from DONE into IDLE
    task automatic run(input bit noisy, input bit already_loaded, input bit chain);
        int               cyc;
        bit               gapped;
        logic [ACC_W-1:0] eu;
        logic [ACC_W-1:0] es;
        eu     = ref_sum(1'b0);
        es     = ref_sum(1'b1);
        gapped = 1'b0;
        cyc    = 1;
        if (!already_loaded) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        check_ctl("load", 1'b1, 1'b1, 1'b0);
        check_eq("hold_u", 64'(bus_u.res_out), 64'(prev_u));
        check_eq("hold_s", 64'(bus_s.res_out), 64'(prev_s));
        for (int k = 0; k < N; k++) begin
            for (int g = 0; g < gap_arr[k]; g++) begin
                gapped    = 1'b1;
                in_valid  = 1'b0;
                main_in   = DW'($urandom);
                weight_in = DW'($urandom);
                start     = noisy;
                tick();
                cyc++;
                start = 1'b0;
                check_eq("gap_ready", 64'(bus_u.in_ready), 64'd1);
            end
            in_valid  = 1'b1;
            main_in   = a_arr[k];
            weight_in = b_arr[k];
            start     = noisy && (k == 1);
            tick();
            cyc++;
            start = 1'b0;
            check_eq("hs_ready", 64'(bus_s.in_ready), 64'(k < N - 1));
        end
        check_ctl("flush", 1'b0, 1'b1, 1'b0);
        in_valid  = noisy;
        main_in   = DW'($urandom);
        weight_in = DW'($urandom);
        tick();
        cyc++;
        in_valid = 1'b0;
        check_ctl("done", 1'b0, 1'b0, 1'b1);
        check_eq("done_s", 64'(bus_s.done), 64'd1);
        check_eq("res_u", 64'(bus_u.res_out), 64'(eu));
        check_eq("res_s", 64'(bus_s.res_out), 64'(es));
        if (!gapped && !already_loaded) check_eq("latency", 64'(cyc), 64'(N + 2));
        prev_u = eu;
        prev_s = es;
        start  = noisy || chain;
        tick();
        check_ctl("idle", 1'b0, 1'b0, 1'b0);
        if (chain) begin
            tick();
            start = 1'b0;
            check_eq("chain_ready", 64'(bus_u.in_ready), 64'd1);
        end else begin
            start = 1'b0;
            tick();
            check_eq("idle2_ready", 64'(bus_s.in_ready), 64'd0);
            check_eq("idle_res", 64'(bus_s.res_out), 64'(es));
        end
    endtask

    task automatic rand_pairs();
        for (int i = 0; i < N; i++) begin
            a_arr[i] = DW'($urandom);
            b_arr[i] = DW'($urandom);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        main_in   = '0;
        weight_in = '0;
        prev_u    = '0;
        prev_s    = '0;
        clear_gaps();
        tick();
        tick();
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        check_eq("reset_res", 64'(bus_s.res_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Unsigned maximum, back to back
        for (int i = 0; i < N; i++) begin a_arr[i] = 8'd255; b_arr[i] = 8'd255; end
        run(1'b0, 1'b0, 1'b0);
        check_eq("tp_umax", 64'(bus_u.res_out), 64'd260100);

        // Signed mix
        a_arr[0] = 8'h80; b_arr[0] = 8'h80;
        a_arr[1] = 8'h7F; b_arr[1] = 8'h80;
        a_arr[2] = 8'hFF; b_arr[2] = 8'h01;
        a_arr[3] = 8'h03; b_arr[3] = 8'h05;
        run(1'b0, 1'b0, 1'b0);
        check_eq("tp_smix", 64'(bus_s.res_out), 64'd142);

        // Gapped stream
        for (int i = 0; i < N; i++) begin
            a_arr[i] = DW'(2 * i + 1);
            b_arr[i] = DW'(2 * i + 2);
        end
        gap_arr[2] = 3;
        run(1'b0, 1'b0, 1'b0);
        check_eq("tp_gap", 64'(bus_u.res_out), 64'd100);
        clear_gaps();

        // Stray starts and a surplus pair
        rand_pairs();
        run(1'b1, 1'b0, 1'b0);

        // Start held from DONE into IDLE begins the next run
        rand_pairs();
        run(1'b0, 1'b0, 1'b1);
        rand_pairs();
        run(1'b0, 1'b1, 1'b0);

        // Asynchronous reset after two handshakes
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid  = 1'b1;
            main_in   = 8'd9;
            weight_in = 8'd7;
            tick();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_ctl("abort", 1'b0, 1'b0, 1'b0);
        check_eq("abort_res_u", 64'(bus_u.res_out), 64'd0);
        check_eq("abort_res_s", 64'(bus_s.res_out), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        prev_u = '0;
        prev_s = '0;
        tick();
        check_eq("post_abort_done", 64'(bus_s.done), 64'd0);
        for (int i = 0; i < N; i++) begin a_arr[i] = 8'd2; b_arr[i] = 8'd3; end
        run(1'b0, 1'b0, 1'b0);
        check_eq("tp_rst24", 64'(bus_s.res_out), 64'd24);

        // Negative signed sum: clamped when ReLU is built in
        for (int i = 0; i < N; i++) begin a_arr[i] = 8'hF6; b_arr[i] = 8'h0A; end
        run(1'b0, 1'b0, 1'b0);
`ifdef MAC_NEURON_RELU_EN
        check_eq("tp_relu", 64'(bus_s.res_out), 64'd0);
`else
        check_eq("tp_relu", 64'(bus_s.res_out), 64'h3FE70);
`endif
        check_eq("tp_relu_u", 64'(bus_u.res_out), 64'd9840);

        for (int r = 0; r < 20; r++) begin
            rand_pairs();
            for (int i = 0; i < N; i++) gap_arr[i] = int'($urandom_range(0, 2));
            run(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
